// File: rtl/store_buffer_if.sv
// Store buffer port bundle: store intake, memory drain and load forwarding.
// master drives stores, grants and load lookups; slave is the buffer itself.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [31:0] st_pc;
  logic        drain_en;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        empty;

  modport master (
    output st_valid, st_addr, st_wdata, st_pc,
    output drain_en, ld_addr,
    input  st_ready, dm_we, dm_addr, dm_wd, dm_pc,
    input  ld_hit, ld_data, empty
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_pc,
    input  drain_en, ld_addr,
    output st_ready, dm_we, dm_addr, dm_wd, dm_pc,
    output ld_hit, ld_data, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Word-granular FIFO of pending stores ahead of data memory.
// Drains one store per granted cycle and forwards youngest match to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic             push;
  logic             pop;
  logic             nonempty;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] idx;
  logic             unused_lo;

  assign unused_lo   = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign nonempty    = (count != '0);
  assign sb.st_ready = (count < FULL);
  assign sb.empty    = !nonempty;
  assign sb.dm_we    = nonempty && sb.drain_en;
  assign push        = sb.st_valid && sb.st_ready;
  assign pop         = sb.dm_we;

  assign sb.dm_addr  = nonempty ? {addr_q[head], 2'b00} : '0;
  assign sb.dm_wd    = nonempty ? data_q[head] : '0;
  assign sb.dm_pc    = nonempty ? pc_q[head] : '0;
  assign sb.ld_hit   = fwd_hit;
  assign sb.ld_data  = fwd_data;

  // Pointer and occupancy bookkeeping; count alone tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload is written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= sb.st_addr[31:2];
      data_q[tail] <= sb.st_wdata;
      pc_q[tail]   <= sb.st_pc;
    end
  end

  // Scan oldest to youngest so the last match wins (youngest store).
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) &&
          (addr_q[idx] == sb.ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue model plus directed cases.
// Random phase holds a refused store stable until it is accepted.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  logic clk;
  logic reset;
  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  logic [31:0] dlog[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model outputs derived from the pending-store queue.
  logic        e_ready, e_we, e_hit;
  logic [31:0] e_addr, e_wd, e_pc, e_ld;
  always @(negedge clk) begin
    e_ready = mq.size() < DEPTH;
    e_we    = (mq.size() != 0) && sb.drain_en;
    e_addr  = 0;
    e_wd    = 0;
    e_pc    = 0;
    if (mq.size() != 0) begin
      e_addr = {mq[0].a, 2'b00};
      e_wd   = mq[0].d;
      e_pc   = mq[0].p;
    end
    e_hit = 1'b0;
    e_ld  = 0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_hit && mq[i].a == sb.ld_addr[31:2]) begin
        e_hit = 1'b1;
        e_ld  = mq[i].d;
      end
    end
    chk("m_st_ready", 32'(sb.st_ready), 32'(e_ready));
    chk("m_empty", 32'(sb.empty), 32'(mq.size() == 0));
    chk("m_dm_we", 32'(sb.dm_we), 32'(e_we));
    chk("m_dm_addr", sb.dm_addr, e_addr);
    chk("m_dm_wd", sb.dm_wd, e_wd);
    chk("m_dm_pc", sb.dm_pc, e_pc);
    chk("m_ld_hit", 32'(sb.ld_hit), 32'(e_hit));
    chk("m_ld_data", sb.ld_data, e_ld);
  end

  // Model state advance and drain trace at each rising edge.
  logic m_r, m_w;
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
    end else begin
      if (sb.dm_we) dlog.push_back(sb.dm_addr);
      m_r = mq.size() < DEPTH;
      m_w = (mq.size() != 0) && sb.drain_en;
      if (m_w) void'(mq.pop_front());
      if (sb.st_valid && m_r)
        mq.push_back('{sb.st_addr[31:2], sb.st_wdata, sb.st_pc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] p);
    sb.st_valid = v;
    sb.st_addr  = a;
    sb.st_wdata = d;
    sb.st_pc    = p;
  endtask

  task automatic drain_all();
    bit done;
    done = 0;
    sb.st_valid = 1'b0;
    sb.drain_en = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (sb.empty) done = 1;
      else step();
    end
    chk("drain_timeout", 32'(done), 32'd1);
    step();
  endtask

  logic [31:0] exp_a[10];
  logic        rdy;

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0);
    sb.drain_en = 1'b0;
    sb.ld_addr  = 32'h0000_0000;
    step();
    step();
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ready", 32'(sb.st_ready), 32'd1);
      chk("idle_empty", 32'(sb.empty), 32'd1);
      chk("idle_we", 32'(sb.dm_we), 32'd0);
      chk("idle_hit", 32'(sb.ld_hit), 32'd0);
      chk("idle_ld", sb.ld_data, 32'd0);
      step();
    end

    sb.drain_en = 1'b1;
    drv(1, 32'h10, 32'hDEAD_BEEF, 32'h3000);
    step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("one_we", 32'(sb.dm_we), 32'd1);
    chk("one_addr", sb.dm_addr, 32'h10);
    chk("one_wd", sb.dm_wd, 32'hDEAD_BEEF);
    chk("one_pc", sb.dm_pc, 32'h3000);
    step();
    @(negedge clk);
    chk("one_empty", 32'(sb.empty), 32'd1);
    step();

    dlog.delete();
    sb.drain_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'(4 * k), 32'hA000 + 32'(k), 32'h4000 + 32'(4 * k));
      step();
    end
    drv(1, 32'h10, 32'hA004, 32'h4010);
    @(negedge clk);
    chk("full_ready", 32'(sb.st_ready), 32'd0);
    step();
    @(negedge clk);
    chk("full_hold", 32'(sb.st_ready), 32'd0);
    step();
    sb.drain_en = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", 32'(sb.st_ready), 32'd0);
    chk("full_pop_we", 32'(sb.dm_we), 32'd1);
    step();
    @(negedge clk);
    chk("freed_ready", 32'(sb.st_ready), 32'd1);
    step();
    drain_all();
    chk("order_n", 32'(dlog.size()), 32'd5);
    for (int k = 0; k < 5 && k < dlog.size(); k++)
      chk("order_addr", dlog[k], 32'(4 * k));

    sb.drain_en = 1'b0;
    drv(1, 32'h20, 32'h1111_1111, 32'h5000);
    step();
    drv(1, 32'h20, 32'h2222_2222, 32'h5004);
    step();
    drv(1, 32'h24, 32'h3333_3333, 32'h5008);
    step();
    drv(0, 0, 0, 0);
    sb.ld_addr = 32'h23;
    @(negedge clk);
    chk("fwd_hit", 32'(sb.ld_hit), 32'd1);
    chk("fwd_data", sb.ld_data, 32'h2222_2222);
    sb.ld_addr = 32'h28;
    @(negedge clk);
    chk("fwd_miss", 32'(sb.ld_hit), 32'd0);
    chk("fwd_zero", sb.ld_data, 32'd0);
    step();
    sb.ld_addr = 32'h0;
    drain_all();

    dlog.delete();
    sb.drain_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_a[k] = 32'h100 + 32'(4 * k);
      drv(1, exp_a[k], $urandom, $urandom);
      if (k > 0) begin
        @(negedge clk);
        chk("stream_we", 32'(sb.dm_we), 32'd1);
      end
      step();
    end
    drain_all();
    chk("stream_n", 32'(dlog.size()), 32'd10);
    for (int k = 0; k < 10 && k < dlog.size(); k++)
      chk("stream_order", dlog[k], exp_a[k]);

    sb.drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv(1, 32'h200 + 32'(4 * k), 32'hB0 + 32'(k), 32'h6000);
      step();
    end
    dlog.delete();
    drv(1, 32'h20C, 32'hB3, 32'h6000);
    sb.drain_en = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    drv(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_we", 32'(sb.dm_we), 32'd0);
    for (int k = 0; k < 4; k++) step();
    chk("rst_no_stale", 32'(dlog.size()), 32'd0);

    for (int k = 0; k < 400; k++) begin
      if (!(sb.st_valid && !rdy))
        drv(1'($urandom_range(0, 1)),
            {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)},
            $urandom, $urandom);
      sb.drain_en = 1'($urandom_range(0, 2) != 0);
      sb.ld_addr  = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      reset = ($urandom_range(0, 99) == 0);
      if (reset) sb.st_valid = 1'b0;
      @(negedge clk);
      rdy = sb.st_ready;
      step();
    end
    reset = 1'b0;
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular FIFO of pending stores that sits directly upstream of the data memory.
- Accepts stores from the execute/memory stage and drains them to the data-memory write port one per cycle when the port is granted.
- Forwards buffered store data to loads so a load never reads stale memory.
- Provides a full-based stall and an empty flag used for fences and end-of-test drain.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge.
- st_valid  input  1  store request this cycle.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  32  store byte address; bits [1:0] ignored.
- st_wdata  input  32  store data.
- st_pc  input  32  PC of the store instruction, carried for the memory write trace.
- drain_en  input  1  data-memory write port granted this cycle (low while the port is in use elsewhere).
- dm_we  output  1  write strobe to data memory.
- dm_addr  output  32  head entry address, with [1:0] forced to 0.
- dm_wd  output  32  head entry data.
- dm_pc  output  32  head entry PC.
- ld_addr  input  32  load address for forwarding lookup.
- ld_hit  output  1  a buffered store matches ld_addr[31:2].
- ld_data  output  32  forwarded data; 0 when ld_hit = 0.
- empty  output  1  no entries buffered.

Behaviour:
- State:
  - DEPTH entries of {addr[31:2], data, pc}.
  - Head pointer and tail pointer, PTR_W bits each, wrapping modulo DEPTH.
  - count, PTR_W+1 bits, range 0..DEPTH.
- Reset:
  - count = 0; head and tail pointers = 0.
  - Entry contents are don't-care; no entry is valid after reset.
  - Resulting outputs: st_ready = 1, empty = 1, dm_we = 0, ld_hit = 0, ld_data = 0.
  - Reset dominates a simultaneous push or pop, and discards any pending stores mid-operation.
- Push:
  - push = st_valid && st_ready, where st_ready = (count < DEPTH).
  - On push, write the entry at the tail and advance the tail by 1.
  - A store presented while st_ready = 0 is not taken. The upstream stage must hold st_valid and the store's fields stable until st_ready = 1.
- Pop:
  - dm_we = (count != 0) && drain_en, combinational from registered state and drain_en.
  - dm_addr, dm_wd and dm_pc always reflect the head entry. They are 0 when empty.
  - On pop (dm_we = 1), data memory writes at this edge, and the head advances by 1 at the same edge.
- Latency:
  - A store pushed at edge N is at the head no earlier than cycle N+1.
  - There is no same-cycle pass-through, even when the buffer is empty.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - Full buffer: st_ready = 0 during that cycle regardless of a pop. The freed slot accepts a store at the following cycle.
  - Empty buffer: only the push happens, since dm_we = 0.
- Ordering: entries drain strictly in push order. Two stores to the same word both reach memory, oldest first.
- Forwarding (combinational):
  - Compare ld_addr[31:2] against every valid entry, including the head being popped this cycle; its memory write is not visible until the edge.
  - On multiple matches, return the youngest matching entry (the one closest to the tail).
  - A store being pushed this cycle is not yet visible to forwarding.
  - The load stage uses ld_data when ld_hit = 1, otherwise the memory read data.
- empty = (count == 0). The pipeline uses it for fences and end-of-program drain.
- Pointer wrap: pointers wrap to 0 after DEPTH-1. The full and empty distinction comes from count, never from pointer equality alone.

Test Plan:
- Reset, then idle -> st_ready = 1, empty = 1, dm_we = 0, ld_hit = 0, ld_data = 0 every cycle.
- One push {addr 0x0000_0010, data 0xDEAD_BEEF, pc 0x0000_3000} with drain_en = 1 -> dm_we = 1 the next cycle with dm_addr = 0x10, dm_wd = 0xDEADBEEF, dm_pc = 0x3000; empty = 1 one cycle later.
- drain_en = 0; push 4 stores to 0x0, 0x4, 0x8, 0xC -> st_ready = 0 after the 4th. A 5th store (0x10) is held. Raise drain_en -> drain order 0x0, 0x4, 0x8, 0xC, 0x10; the 5th is accepted the cycle after the first pop.
- drain_en = 0; push 0x20 = 0x1111_1111, then 0x20 = 0x2222_2222, then 0x24 = 0x3333_3333. Set ld_addr = 0x23 -> ld_hit = 1, ld_data = 0x22222222. Set ld_addr = 0x28 -> ld_hit = 0, ld_data = 0.
- Steady stream of stores with drain_en = 1 for 10 cycles -> a push and a pop every cycle; count stays 1; pointers wrap past 3 with correct data order.
- Fill 3 entries, then assert reset for one cycle during a push and a pop -> all state cleared: empty = 1, dm_we = 0 the next cycle, no stale data drains afterwards.
